// File: rtl/prime_tester_if.sv
// Request/response bundle between a requester and the prime tester.
// Handshake: the requester may raise go for one cycle only while ready=1;
// arg must be valid on that same edge. The responder drops ready on the
// accepting edge and raises it again together with a fresh res. A go
// seen while ready=0 is ignored and latches the sticky error flag.
interface prime_tester_if #(
    parameter int WIDTH = 16
);
    logic             go;
    logic [WIDTH-1:0] arg;
    logic             ready;
    logic             error;
    logic             res;

    modport master (
        output go,
        output arg,
        input  ready,
        input  error,
        input  res
    );

    modport slave (
        input  go,
        input  arg,
        output ready,
        output error,
        output res
    );
endinterface

// File: rtl/prime_tester.sv
// Iterative trial-division primality tester.
// Divisors d = 2, 3, 4, ... are tried while d*d <= n; sq tracks d*d
// incrementally (sq += 2d+1) so no multiplier is needed. Each trial runs a
// restoring remainder over n, one bit per cycle, MSB first.
module prime_tester #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    prime_tester_if.slave bus,
    output logic [1:0]    dbg_state
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DIV   = 2'd2,
        S_NEXT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [2*WIDTH-1:0] sq_q, sq_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;
    logic               res_q, res_d;

    // Partial remainder with the next dividend bit shifted in. The remainder
    // is always < d, so the shifted value fits WIDTH+1 bits and the
    // difference (when taken) fits WIDTH bits.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_sub;

    // Remainder step datapath for the DIV state.
    always_comb begin
        rem_shift = {rem_q, n_q[idx_q]};
        rem_sub   = rem_shift[WIDTH-1:0] - d_q;
    end

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        sq_d    = sq_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        error_d = error_q;
        res_d   = res_q;

        // A request while busy is dropped but remembered as a violation.
        // This also covers go on the edge where ready rises.
        if (bus.go && !ready_q) begin
            error_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    n_d     = bus.arg;
                    d_d     = WIDTH'(2);
                    sq_d    = (2*WIDTH)'(4);
                    ready_d = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (n_q < WIDTH'(2)) begin
                    res_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else if (sq_q > {{WIDTH{1'b0}}, n_q}) begin
                    // No divisor up to sqrt(n) was found.
                    res_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rem_d   = '0;
                    idx_d   = IW'(WIDTH - 1);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (rem_shift >= {1'b0, d_q}) begin
                    rem_d = rem_sub;
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                end
                if (idx_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_NEXT: begin
                if (rem_q == '0) begin
                    res_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // (d+1)^2 = d^2 + 2d + 1
                    d_d     = d_q + WIDTH'(1);
                    sq_d    = sq_q + (2*WIDTH)'({d_q, 1'b1});
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any computation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            d_q     <= '0;
            sq_q    <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            sq_q    <= sq_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            error_q <= error_d;
            res_q   <= res_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.error = error_q;
    assign bus.res   = res_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prime_tester.sv
// Self-checking bench for prime_tester: a driver issues requests and
// pushes the reference result (primality and busy-cycle count) into a
// queue; a monitor pops and compares each time ready rises.
module tb_prime_tester;

    localparam int          WIDTH  = 16;
    localparam int unsigned TRIAL  = WIDTH + 2;
    localparam int          BUDGET = 6000;
    localparam int          EW     = WIDTH + 33;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    prime_tester_if #(.WIDTH(WIDTH)) bus ();

    prime_tester #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and run-time guard.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state: entry = {arg, res, busy_cycles}.
    logic [EW-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic          exp_error = 1'b0;

    // Reference model: trial division straight from the definition of a
    // prime, plus the latency rule of one CHECK + one full trial per divisor.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a);
        int unsigned n;
        int unsigned k;
        n = a;
        if (n < 2) return {a, 1'b0, 32'd1};
        k = 0;
        for (int unsigned d = 2; d * d <= n; d++) begin
            k++;
            if (n % d == 0) return {a, 1'b0, 32'(k * TRIAL)};
        end
        return {a, 1'b1, 32'(1 + k * TRIAL)};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: wait (bounded) for idle, present one request, randomize arg after.
    task automatic do_req(input logic [WIDTH-1:0] a);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: ready stuck at %b, wanted 1", bus.ready);
            return;
        end
        bus.go  = 1'b1;
        bus.arg = a;
        exp_q.push_back(model(a));
        @(posedge clk); #1;
        bus.go  = 1'b0;
        bus.arg = WIDTH'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: ready %b after %0d cycles, wanted 1", bus.ready, n);
        end
        // Let the monitor see the rising ready before moving on.
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_error = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: counts busy cycles and checks each completion against the queue.
    int   busy_cnt = 0;
    logic prev_ready = 1'b1;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst === 1'b1) begin
            exp_q.delete();
            busy_cnt   = 0;
            prev_ready = 1'b1;
        end else begin
            if (bus.ready !== 1'b1) begin
                busy_cnt++;
            end else if (prev_ready !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: completion with empty queue, busy %0d", busy_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.res !== e[32]) begin
                        errors++;
                        $display("FAIL res arg=%0d: got %b expected %b", e[EW-1:33], bus.res, e[32]);
                    end
                    checks++;
                    if (busy_cnt != int'(e[31:0])) begin
                        errors++;
                        $display("FAIL latency arg=%0d: got %0d expected %0d", e[EW-1:33], busy_cnt, e[31:0]);
                    end
                    checks++;
                    if (bus.error !== exp_error) begin
                        errors++;
                        $display("FAIL error_flag arg=%0d: got %b expected %b", e[EW-1:33], bus.error, exp_error);
                    end
                end
                busy_cnt = 0;
            end
            prev_ready = bus.ready;
        end
    end

    // Stimulus sequence.
    initial begin
        logic [WIDTH-1:0] directed[7];
        directed = '{16'd2, 16'd1, 16'd4, 16'd9, 16'd5, 16'd65521, 16'd65535};

        rst     = 1'b1;
        bus.go  = 1'b0;
        bus.arg = '0;
        @(posedge clk); #1;
        do_reset();
        check_bit("reset_ready", bus.ready, 1'b1);
        check_bit("reset_res",   bus.res,   1'b0);
        check_bit("reset_error", bus.error, 1'b0);

        // go held across the edge where ready rises: only one request taken.
        bus.go  = 1'b1;
        bus.arg = 16'd2;
        exp_q.push_back(model(16'd2));
        @(posedge clk); #1;
        check_bit("held_go_busy", bus.ready, 1'b0);
        exp_error = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        check_bit("held_go_ready", bus.ready, 1'b1);
        check_bit("held_go_error", bus.error, 1'b1);
        @(posedge clk); #1;
        check_bit("held_go_not_accepted", bus.ready, 1'b1);
        @(negedge clk); #1;

        do_reset();
        foreach (directed[i]) begin
            do_req(directed[i]);
            wait_idle();
        end
        check_bit("directed_no_error", bus.error, 1'b0);

        // Violation: go during busy on arg=5; result unaffected, flag sticks.
        do_req(16'd5);
        repeat (3) begin @(posedge clk); #1; end
        bus.go  = 1'b1;
        bus.arg = 16'd4;
        @(posedge clk); #1;
        bus.go = 1'b0;
        exp_error = 1'b1;
        wait_idle();
        check_bit("violation_error", bus.error, 1'b1);
        do_req(16'd4);
        wait_idle();
        check_bit("violation_sticky", bus.error, 1'b1);

        // Reset in the middle of a long computation.
        do_req(16'd65521);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_error = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_bit("midreset_ready", bus.ready, 1'b1);
        check_bit("midreset_res",   bus.res,   1'b0);
        check_bit("midreset_error", bus.error, 1'b0);
        do_req(16'd3);
        wait_idle();

        // Random operands, mostly small to bound run time.
        for (int i = 0; i < 40; i++) begin
            do_req(WIDTH'($urandom_range(0, 3000)));
            wait_idle();
        end
        for (int i = 0; i < 6; i++) begin
            do_req(WIDTH'($urandom_range(0, 65535)));
            wait_idle();
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
